// File: rtl/period_meter.sv
// period_meter: measures high time, low time and period of a slow
// clk-synchronous signal, presenting each (high, low) pair on a
// valid/ready port. Counters saturate; a result that completes while
// the previous one is still unaccepted is dropped and flagged in overrun.
module period_meter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hi_len,
  output logic [WIDTH-1:0] lo_len,
  output logic [WIDTH:0]   period,
  output logic             sat,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HI, MEAS_LO} state_t;

  state_t           state_q, state_d;
  logic             s_q, s_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_hold_q, hi_hold_d;
  logic             sat_acc_q, sat_acc_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] hi_len_q, hi_len_d;
  logic [WIDTH-1:0] lo_len_q, lo_len_d;
  logic [WIDTH:0]   period_q, period_d;
  logic             sat_q, sat_d;
  logic             overrun_q, overrun_d;

  logic             rise, fall, cnt_max, complete;
  logic [WIDTH-1:0] cnt_inc;

  // Next-state, counter and result/handshake logic.
  always_comb begin
    state_d     = state_q;
    s_d         = sig_in;
    cnt_d       = cnt_q;
    hi_hold_d   = hi_hold_q;
    sat_acc_d   = sat_acc_q;
    out_valid_d = out_valid_q;
    hi_len_d    = hi_len_q;
    lo_len_d    = lo_len_q;
    period_d    = period_q;
    sat_d       = sat_q;
    overrun_d   = overrun_q;
    complete    = 1'b0;

    rise    = sig_in & ~s_q;
    fall    = ~sig_in & s_q;
    cnt_max = (cnt_q == {WIDTH{1'b1}});
    // Counter holds at max instead of wrapping.
    cnt_inc = cnt_max ? cnt_q : cnt_q + WIDTH'(1);

    if (!en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      sat_acc_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = WAIT_RISE;
        end
        // Throw away the partial period in progress when enabled.
        WAIT_RISE: begin
          if (rise) begin
            cnt_d     = WIDTH'(1);
            sat_acc_d = 1'b0;
            state_d   = MEAS_HI;
          end
        end
        MEAS_HI: begin
          if (fall) begin
            hi_hold_d = cnt_q;
            cnt_d     = WIDTH'(1);
            state_d   = MEAS_LO;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_max) sat_acc_d = 1'b1;
          end
        end
        MEAS_LO: begin
          // The completing rise is also cycle 1 of the next high phase.
          if (rise) begin
            complete  = 1'b1;
            cnt_d     = WIDTH'(1);
            sat_acc_d = 1'b0;
            state_d   = MEAS_HI;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_max) sat_acc_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (complete) begin
      if (!out_valid_q || out_ready) begin
        hi_len_d    = hi_hold_q;
        lo_len_d    = cnt_q;
        period_d    = {1'b0, hi_hold_q} + {1'b0, cnt_q};
        sat_d       = sat_acc_q;
        out_valid_d = 1'b1;
      end else begin
        overrun_d   = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= 1'b0;
      cnt_q       <= '0;
      hi_hold_q   <= '0;
      sat_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      hi_len_q    <= '0;
      lo_len_q    <= '0;
      period_q    <= '0;
      sat_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      hi_hold_q   <= hi_hold_d;
      sat_acc_q   <= sat_acc_d;
      out_valid_q <= out_valid_d;
      hi_len_q    <= hi_len_d;
      lo_len_q    <= lo_len_d;
      period_q    <= period_d;
      sat_q       <= sat_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign hi_len    = hi_len_q;
  assign lo_len    = lo_len_q;
  assign period    = period_q;
  assign sat       = sat_q;
  assign overrun   = overrun_q;

endmodule
